// File: rtl/nib2byte_framer.sv
// Packs 4-bit nibbles into bytes, frames them into FRAME_BYTES-byte packets
// and queues them in a show-ahead FIFO with valid/ready toward the byte sink.
module nib2byte_framer #(
  parameter int FRAME_BYTES = 188,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       iclk,
  input  logic       irst,
  input  logic [3:0] idat,
  input  logic       isop,
  input  logic       ival,
  output logic       oreq,
  input  logic       ireq,
  output logic [7:0] odat,
  output logic       oval,
  output logic       osop,
  output logic       oeop,
  output logic       oerr,
  output logic       oovf
);

  localparam int BW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  state_t        state, state_n;
  logic [3:0]    lo_reg, lo_n;
  logic [BW-1:0] byte_cnt, cnt_n;
  logic          push, push_sop, push_eop, err_n;
  logic [7:0]    push_dat;

  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state    <= IDLE;
      lo_reg   <= '0;
      byte_cnt <= '0;
    end else begin
      state    <= state_n;
      lo_reg   <= lo_n;
      byte_cnt <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    lo_n     = lo_reg;
    cnt_n    = byte_cnt;
    push     = 1'b0;
    push_sop = 1'b0;
    push_eop = 1'b0;
    push_dat = {idat, lo_reg};
    err_n    = 1'b0;
    if (ival) begin
      if (isop) begin
        // Any sop restarts framing; inside a frame it also flags the truncation.
        err_n   = (state != IDLE);
        lo_n    = idat;
        cnt_n   = '0;
        state_n = HI;
      end else begin
        case (state)
          LO: begin
            lo_n    = idat;
            state_n = HI;
          end
          HI: begin
            push     = 1'b1;
            push_sop = (byte_cnt == '0);
            push_eop = (byte_cnt == BW'(FRAME_BYTES - 1));
            if (push_eop) begin
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              cnt_n   = byte_cnt + BW'(1);
              state_n = LO;
            end
          end
          default: state_n = IDLE;
        endcase
      end
    end
  end

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, pop, wr_en;
  logic [9:0]    head;

  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign pop   = !empty && ireq;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge iclk) begin
    if (wr_en) mem[wr_ptr] <= {push_eop, push_sop, push_dat};
  end

  // A push into a full FIFO with no pop is dropped and latches the overflow flag.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      oerr   <= 1'b0;
      oovf   <= 1'b0;
    end else begin
      oerr <= err_n;
      if (push && full && !pop) oovf <= 1'b1;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];
  assign oval = !empty;
  assign odat = oval ? head[7:0] : 8'h00;
  assign osop = oval && head[8];
  assign oeop = oval && head[9];
  assign oreq = (count <= CW'(FIFO_DEPTH - 2));

endmodule

// File: tb/tb_nib2byte_framer.sv
// Self-checking bench for nib2byte_framer: vector tables, corner sequences and
// randomized traffic compared against a queue-based framing model.
module tb_nib2byte_framer;

  localparam int FB = 4;
  localparam int FD = 8;

  logic       iclk, irst;
  logic [3:0] idat;
  logic       isop, ival, ireq;
  logic       oreq, oval, osop, oeop, oerr, oovf;
  logic [7:0] odat;

  int checks   = 0;
  int failures = 0;

  nib2byte_framer #(.FRAME_BYTES(FB), .FIFO_DEPTH(FD)) dut (
    .iclk(iclk), .irst(irst), .idat(idat), .isop(isop), .ival(ival),
    .oreq(oreq), .ireq(ireq), .odat(odat), .oval(oval), .osop(osop),
    .oeop(oeop), .oerr(oerr), .oovf(oovf)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Model: collected nibbles of the open frame, bytes so far, and a bounded byte queue.
  logic [9:0] m_q[$];
  bit         m_in_frame, m_have_lo, m_ovf, m_err;
  logic [3:0] m_lo;
  int         m_idx;

  typedef struct {
    logic       ival, isop;
    logic [3:0] idat;
    logic       ireq;
    logic       eval;
    logic [7:0] edat;
    logic       esop, eeop, eerr;
  } vec_t;

  vec_t basic_v[9];
  vec_t prem_v[13];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_q.delete();
    m_in_frame = 0; m_have_lo = 0; m_ovf = 0; m_err = 0; m_lo = 0; m_idx = 0;
  endtask

  task automatic modelStep(input logic v, input logic s, input logic [3:0] d, input logic r);
    bit do_pop, was_full, have_byte;
    logic [9:0] b;
    have_byte = 0;
    b = '0;
    m_err = 0;
    do_pop = (m_q.size() > 0) && r;
    was_full = (m_q.size() == FD);
    if (v) begin
      if (s) begin
        m_err = m_in_frame;
        m_in_frame = 1; m_have_lo = 1; m_lo = d; m_idx = 0;
      end else if (m_in_frame) begin
        if (m_have_lo) begin
          have_byte = 1;
          b = {1'(m_idx == FB - 1), 1'(m_idx == 0), d, m_lo};
          m_idx++;
          m_have_lo = 0;
          if (m_idx == FB) begin m_in_frame = 0; m_idx = 0; end
        end else begin
          m_have_lo = 1; m_lo = d;
        end
      end
    end
    if (do_pop) void'(m_q.pop_front());
    if (have_byte) begin
      if (was_full && !do_pop) m_ovf = 1;
      else m_q.push_back(b);
    end
  endtask

  task automatic compareModel();
    checkOutput("oval", oval, m_q.size() > 0);
    if (m_q.size() > 0) begin
      checkOutput("odat", odat, m_q[0][7:0]);
      checkOutput("osop", osop, m_q[0][8]);
      checkOutput("oeop", oeop, m_q[0][9]);
    end
    checkOutput("oreq", oreq, m_q.size() <= FD - 2);
    checkOutput("oerr", oerr, m_err);
    checkOutput("oovf", oovf, m_ovf);
  endtask

  task automatic applyStimulus(input logic v, input logic s, input logic [3:0] d, input logic r);
    ival = v; isop = s; idat = d; ireq = r;
    @(posedge iclk);
    modelStep(v, s, d, r);
    #1;
    compareModel();
  endtask

  task automatic checkReset();
    checkOutput("rst_oval", oval, 0);
    checkOutput("rst_osop", osop, 0);
    checkOutput("rst_oeop", oeop, 0);
    checkOutput("rst_oerr", oerr, 0);
    checkOutput("rst_oovf", oovf, 0);
    checkOutput("rst_odat", odat, 0);
    checkOutput("rst_oreq", oreq, 1);
  endtask

  task automatic doReset();
    ival = 0; isop = 0; idat = 0;
    irst = 1'b0;
    #2;
    modelReset();
    checkReset();
    @(negedge iclk);
    irst = 1'b1;
  endtask

  task automatic runTable(input string name, input vec_t v);
    applyStimulus(v.ival, v.isop, v.idat, v.ireq);
    checkOutput({name, "_oval"}, oval, v.eval);
    if (v.eval) begin
      checkOutput({name, "_odat"}, odat, v.edat);
      checkOutput({name, "_osop"}, osop, v.esop);
      checkOutput({name, "_oeop"}, oeop, v.eeop);
    end
    checkOutput({name, "_oerr"}, oerr, v.eerr);
  endtask

  initial begin
    irst = 1'b1; ival = 0; isop = 0; idat = 0; ireq = 1;
    modelReset();

    // nibbles 1..8 in one frame -> 21(sop) 43 65 87(eop), each visible one cycle after its HI nibble
    basic_v[0] = '{1, 1, 4'h1, 1, 0, 8'h00, 0, 0, 0};
    basic_v[1] = '{1, 0, 4'h2, 1, 1, 8'h21, 1, 0, 0};
    basic_v[2] = '{1, 0, 4'h3, 1, 0, 8'h00, 0, 0, 0};
    basic_v[3] = '{1, 0, 4'h4, 1, 1, 8'h43, 0, 0, 0};
    basic_v[4] = '{1, 0, 4'h5, 1, 0, 8'h00, 0, 0, 0};
    basic_v[5] = '{1, 0, 4'h6, 1, 1, 8'h65, 0, 0, 0};
    basic_v[6] = '{1, 0, 4'h7, 1, 0, 8'h00, 0, 0, 0};
    basic_v[7] = '{1, 0, 4'h8, 1, 1, 8'h87, 0, 1, 0};
    basic_v[8] = '{0, 0, 4'h0, 1, 0, 8'h00, 0, 0, 0};

    // sop on nibble 5 truncates the frame; the new frame is 65(sop) 87 A9 CB(eop)
    prem_v[0]  = '{1, 1, 4'h1, 1, 0, 8'h00, 0, 0, 0};
    prem_v[1]  = '{1, 0, 4'h2, 1, 1, 8'h21, 1, 0, 0};
    prem_v[2]  = '{1, 0, 4'h3, 1, 0, 8'h00, 0, 0, 0};
    prem_v[3]  = '{1, 0, 4'h4, 1, 1, 8'h43, 0, 0, 0};
    prem_v[4]  = '{1, 1, 4'h5, 1, 0, 8'h00, 0, 0, 1};
    prem_v[5]  = '{1, 0, 4'h6, 1, 1, 8'h65, 1, 0, 0};
    prem_v[6]  = '{1, 0, 4'h7, 1, 0, 8'h00, 0, 0, 0};
    prem_v[7]  = '{1, 0, 4'h8, 1, 1, 8'h87, 0, 0, 0};
    prem_v[8]  = '{1, 0, 4'h9, 1, 0, 8'h00, 0, 0, 0};
    prem_v[9]  = '{1, 0, 4'hA, 1, 1, 8'hA9, 0, 0, 0};
    prem_v[10] = '{1, 0, 4'hB, 1, 0, 8'h00, 0, 0, 0};
    prem_v[11] = '{1, 0, 4'hC, 1, 1, 8'hCB, 0, 1, 0};
    prem_v[12] = '{0, 0, 4'h0, 1, 0, 8'h00, 0, 0, 0};

    @(negedge iclk);
    doReset();

    $display("[TB] basic packing");
    foreach (basic_v[i]) runTable("basic", basic_v[i]);

    $display("[TB] idle drop");
    applyStimulus(1, 0, 4'hA, 1);
    applyStimulus(1, 0, 4'hB, 1);
    checkOutput("idle_oval", oval, 0);
    applyStimulus(1, 1, 4'h1, 1);
    applyStimulus(1, 0, 4'h2, 1);
    checkOutput("idle_first_odat", odat, 8'h21);
    checkOutput("idle_first_osop", osop, 1);
    for (int i = 3; i <= 8; i++) applyStimulus(1, 0, 4'(i), 1);
    applyStimulus(0, 0, 4'h0, 1);

    $display("[TB] premature sop");
    foreach (prem_v[i]) runTable("prem", prem_v[i]);

    $display("[TB] backpressure and overflow");
    doReset();
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1, (i % 8) == 0, 4'(i), 0);
      if (i == 11) checkOutput("bp_oreq_at6", oreq, 1);
      if (i == 13) checkOutput("bp_oreq_at7", oreq, 0);
      if (i == 15) checkOutput("bp_oovf_at8", oovf, 0);
      if (i == 17) checkOutput("bp_oovf_set", oovf, 1);
    end
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 4'h0, 1);
    checkOutput("bp_drained", oval, 0);
    checkOutput("bp_oovf_sticky", oovf, 1);

    $display("[TB] full with simultaneous push/pop");
    doReset();
    for (int i = 0; i < 17; i++) applyStimulus(1, (i % 8) == 0, 4'(i), 0);
    applyStimulus(1, 0, 4'h1, 1);
    applyStimulus(0, 0, 4'h0, 0);
    checkOutput("full_oovf", oovf, 0);
    checkOutput("full_oreq", oreq, 0);
    checkOutput("full_oval", oval, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 4'h0, 1);

    $display("[TB] reset mid-frame");
    applyStimulus(1, 1, 4'h3, 0);
    applyStimulus(1, 0, 4'h4, 0);
    applyStimulus(1, 0, 4'h5, 0);
    doReset();
    applyStimulus(1, 1, 4'h1, 1);
    applyStimulus(1, 0, 4'h2, 1);
    checkOutput("rstmid_odat", odat, 8'h21);
    checkOutput("rstmid_osop", osop, 1);
    for (int i = 3; i <= 8; i++) applyStimulus(1, 0, 4'(i), 1);
    applyStimulus(0, 0, 4'h0, 1);

    $display("[TB] random traffic");
    doReset();
    for (int i = 0; i < 3000; i++) begin
      logic v, s, r;
      v = ($urandom_range(3) != 0) && (oreq || ($urandom_range(15) == 0));
      s = ($urandom_range(19) == 0);
      r = ($urandom_range(2) != 0);
      applyStimulus(v, s, 4'($urandom_range(15)), r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
